// File: rtl/overlap_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// overlap_scan_ctrl_pkg
// Shared types and helpers for the tangram board overlap scanner.
//   - PRED_W       : working width of the overlap predicate.
//   - scan_state_t : scanner FSM states.
//   - is_overlap() : true when more than one bit of a hit vector is set.
// ---------------------------------------------------------------------------
package overlap_scan_ctrl_pkg;

    // Hit vectors are zero-extended to this width before the predicate.
    localparam int unsigned PRED_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE,
        FLUSH
    } scan_state_t;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic is_overlap(input logic [PRED_W-1:0] v);
        return (v & (v - {{(PRED_W-1){1'b0}}, 1'b1})) != '0;
    endfunction

endpackage

// File: rtl/overlap_scan_ctrl_raster.sv
// ---------------------------------------------------------------------------
// raster_counter
// Walks x = 0..WIDTH-1 inside y = 0..HEIGHT-1 in raster order.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return to (0,0)
//   adv        : step to the next pixel (wraps after the last one)
//   x, y       : current coordinate
//   last       : current coordinate is (WIDTH-1, HEIGHT-1)
// ---------------------------------------------------------------------------
module raster_counter #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int XW     = 9,
    parameter int YW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/overlap_scan_ctrl.sv
// ---------------------------------------------------------------------------
// overlap_scan_ctrl
// Raster-scans the board once per start, sends pixel coordinates to the
// hit-test engines, classifies the in-order returns and reports coverage,
// overlap statistics and a solved verdict.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort, stall   : scan control
//   target_area           : expected covered pixel count (captured at start)
//   coord_valid/x/y       : request to the hit engines
//   hit_valid, hit_en     : in-order per-shape hit vector return
//   busy, done            : status; done pulses once when results are final
//   covered_cnt, overlap_cnt, first_ovl_x/y/vld, solved : results
//   proto_err             : sticky, a return arrived with nothing outstanding
// ---------------------------------------------------------------------------
module overlap_scan_ctrl
    import overlap_scan_ctrl_pkg::*;
#(
    parameter int MAXSHP = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int XW     = 9,
    parameter int YW     = 8,
    parameter int CNTW   = 17,
    parameter int OUTW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic [CNTW-1:0]   target_area,
    output logic              coord_valid,
    output logic [XW-1:0]     coord_x,
    output logic [YW-1:0]     coord_y,
    input  logic              hit_valid,
    input  logic [MAXSHP-1:0] hit_en,
    output logic              busy,
    output logic              done,
    output logic [CNTW-1:0]   covered_cnt,
    output logic [CNTW-1:0]   overlap_cnt,
    output logic [XW-1:0]     first_ovl_x,
    output logic [YW-1:0]     first_ovl_y,
    output logic              first_ovl_vld,
    output logic              solved,
    output logic              proto_err
);

    scan_state_t     state, state_next;
    logic [OUTW-1:0] outstanding;
    logic [CNTW-1:0] target_q;
    logic [XW-1:0]   ret_x;
    logic [YW-1:0]   ret_y;
    logic            issue_last;
    logic            ret_last_unused;
    logic            start_scan;
    logic            accept;
    logic            tally;
    logic            hit_ovl;

    assign start_scan = (state == IDLE) && start;
    // A beat with nothing outstanding is never accepted; it only flags proto_err.
    assign accept     = hit_valid && (outstanding != '0);
    assign tally      = accept && (state != FLUSH);
    assign hit_ovl    = is_overlap(PRED_W'(hit_en));
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) u_issue (
        .clk(clk), .rst_n(rst_n), .clr(start_scan), .adv(coord_valid),
        .x(coord_x), .y(coord_y), .last(issue_last)
    );

    // Engines answer in order, so a second walker names the returned pixel.
    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) u_return (
        .clk(clk), .rst_n(rst_n), .clr(start_scan), .adv(accept),
        .x(ret_x), .y(ret_y), .last(ret_last_unused)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and issue strobe; abort outranks stall and the issue advance.
    always_comb begin
        state_next  = state;
        coord_valid = 1'b0;
        case (state)
            IDLE:  if (start) state_next = ISSUE;
            ISSUE: begin
                if (abort) begin
                    state_next = FLUSH;
                end else if (!stall) begin
                    coord_valid = 1'b1;
                    if (issue_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort)                   state_next = FLUSH;
                else if (outstanding == '0)  state_next = DONE;
            end
            DONE:  state_next = IDLE;
            FLUSH: if (outstanding == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Requests in flight; a simultaneous issue and return cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({coord_valid, accept})
                2'b10:   outstanding <= outstanding + OUTW'(1);
                2'b01:   outstanding <= outstanding - OUTW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              proto_err <= 1'b0;
        else if (hit_valid && outstanding == '0) proto_err <= 1'b1;
    end

    // Statistics: cleared at start, held after done; solved is set on the
    // DRAIN->DONE edge so it is already valid during the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            covered_cnt   <= '0;
            overlap_cnt   <= '0;
            first_ovl_x   <= '0;
            first_ovl_y   <= '0;
            first_ovl_vld <= 1'b0;
            solved        <= 1'b0;
            target_q      <= '0;
        end else if (start_scan) begin
            covered_cnt   <= '0;
            overlap_cnt   <= '0;
            first_ovl_x   <= '0;
            first_ovl_y   <= '0;
            first_ovl_vld <= 1'b0;
            solved        <= 1'b0;
            target_q      <= target_area;
        end else begin
            if (tally && hit_en != '0 && covered_cnt != '1)
                covered_cnt <= covered_cnt + CNTW'(1);
            if (tally && hit_ovl && overlap_cnt != '1)
                overlap_cnt <= overlap_cnt + CNTW'(1);
            if (tally && hit_ovl && !first_ovl_vld) begin
                first_ovl_x   <= ret_x;
                first_ovl_y   <= ret_y;
                first_ovl_vld <= 1'b1;
            end
            if (state == DRAIN && state_next == DONE)
                solved <= (overlap_cnt == '0) && (covered_cnt == target_q);
        end
    end

endmodule
